// File: rtl/normalize_pre_round_float64.sv
// normalize_pre_round_float64
// Pre-rounding normalizer for float64. It shifts the significand left so
// that its leading one lands on bit 62, and it adjusts the exponent by the
// same amount. The leading-zero count uses a six-step binary search, one
// step per cycle, so the latency is fixed. A start/done handshake in the
// ap_ctrl style controls the block.
module normalize_pre_round_float64 #(
  parameter int EXP_W = 13,
  parameter int SIG_W = 64
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic             zSign,
  input  logic [EXP_W-1:0] zExp,
  input  logic [SIG_W-1:0] zSig,
  output logic             zSign_o,
  output logic [EXP_W-1:0] zExp_o,
  output logic [SIG_W-1:0] zSig_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_ADJ,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic             sign_r;
  logic [EXP_W-1:0] exp_r;
  logic [SIG_W-1:0] w;
  logic [6:0]       clz;
  logic             zero_r;
  logic [2:0]       stage;

  logic             top_zero;
  logic [6:0]       shift_n;

  // Control state register. Reset returns to IDLE immediately and discards the job.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept a job, run six scan steps, adjust, then pulse done.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (ap_start) state_next = S_SCAN;
      S_SCAN: if (stage == 3'd5) state_next = S_ADJ;
      S_ADJ:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Binary-search step. Test the top n bits of the work value (n = 32 >> stage).
  always_comb begin
    top_zero = 1'b0;
    shift_n  = 7'd0;
    case (stage)
      3'd0: begin top_zero = (w[63:32] == 32'd0); shift_n = 7'd32; end
      3'd1: begin top_zero = (w[63:48] == 16'd0); shift_n = 7'd16; end
      3'd2: begin top_zero = (w[63:56] == 8'd0);  shift_n = 7'd8;  end
      3'd3: begin top_zero = (w[63:60] == 4'd0);  shift_n = 7'd4;  end
      3'd4: begin top_zero = (w[63:62] == 2'd0);  shift_n = 7'd2;  end
      3'd5: begin top_zero = (w[63] == 1'b0);     shift_n = 7'd1;  end
      default: begin top_zero = 1'b0; shift_n = 7'd0; end
    endcase
  end

  // Datapath: capture on accept, shift during scan, register the result in ADJ.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sign_r  <= 1'b0;
      exp_r   <= '0;
      w       <= '0;
      clz     <= 7'd0;
      zero_r  <= 1'b0;
      stage   <= 3'd0;
      zSign_o <= 1'b0;
      zExp_o  <= '0;
      zSig_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            sign_r <= zSign;
            exp_r  <= zExp;
            w      <= zSig;
            clz    <= 7'd0;
            zero_r <= (zSig == '0);
            stage  <= 3'd0;
          end
        end
        S_SCAN: begin
          if (top_zero) begin
            w   <= w << shift_n;
            clz <= clz + shift_n;
          end
          stage <= stage + 3'd1;
        end
        S_ADJ: begin
          zSign_o <= sign_r;
          if (zero_r) begin
            zSig_o <= '0;
            zExp_o <= exp_r - 13'd63;
          end else if (clz == 7'd0) begin
            // Bit 63 is set. Shift right by one and jam the lost bit into the sticky position.
            zSig_o <= {1'b0, w[63:1]} | {63'b0, w[0]};
            zExp_o <= exp_r + 13'd1;
          end else begin
            zSig_o <= w >> 1;
            zExp_o <= exp_r - ({6'b0, clz} - 13'd1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ap_done  = (state == S_DONE);
  assign ap_ready = (state == S_DONE);
  assign ap_idle  = (state == S_IDLE) && !ap_start;

endmodule

// File: tb/tb_normalize_pre_round_float64.sv
// Directed testbench for normalize_pre_round_float64.
module tb_normalize_pre_round_float64;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic        zSign;
  logic [12:0] zExp;
  logic [63:0] zSig;
  logic        zSign_o;
  logic [12:0] zExp_o;
  logic [63:0] zSig_o;

  int n_checks = 0;
  int n_fail   = 0;

  normalize_pre_round_float64 dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .zSign    (zSign),
    .zExp     (zExp),
    .zSig     (zSig),
    .zSign_o  (zSign_o),
    .zExp_o   (zExp_o),
    .zSig_o   (zSig_o)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic test_reset();
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    zSign = 1'b0; zExp = '0; zSig = '0;
    repeat (2) @(negedge ap_clk);
    n_checks++;
    if (zSig_o !== 64'd0 || zExp_o !== 13'd0 || zSign_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got sig=%h exp=%h sign=%b, want all 0", zSig_o, zExp_o, zSign_o);
    end
    n_checks++;
    if (ap_done !== 1'b0 || ap_ready !== 1'b0 || ap_idle !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got done=%b ready=%b idle=%b, want 0 0 1", ap_done, ap_ready, ap_idle);
    end
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  // Run one job. The task is entered at a negedge in IDLE. It checks the done cycle, the pulse width and the outputs.
  task automatic test_job(input string name, input logic s, input logic [12:0] e, input logic [63:0] g,
                          input logic es, input logic [12:0] ee, input logic [63:0] eg);
    int done_cycle;
    zSign = s; zExp = e; zSig = g;
    ap_start = 1'b1;
    #1;
    n_checks++;
    if (ap_idle !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_idle_with_start: got %b, want 0", name, ap_idle);
    end
    done_cycle = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge ap_clk);
      #1;
      if (c == 1) begin
        ap_start = 1'b0;
        zSign = ~s; zExp = ~e; zSig = ~g;
      end
      if (ap_done === 1'b1) begin
        done_cycle = c;
        break;
      end
    end
    n_checks++;
    if (done_cycle != 8) begin
      n_fail++;
      $display("[TB] FAIL %s_latency: got done cycle %0d, want 8", name, done_cycle);
    end
    n_checks++;
    if (ap_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_ready: got %b, want 1", name, ap_ready);
    end
    n_checks++;
    if (zSig_o !== eg || zExp_o !== ee || zSign_o !== es) begin
      n_fail++;
      $display("[TB] FAIL %s_result: got sig=%h exp=%h sign=%b, want sig=%h exp=%h sign=%b",
               name, zSig_o, zExp_o, zSign_o, eg, ee, es);
    end
    @(posedge ap_clk);
    #1;
    n_checks++;
    if (ap_done !== 1'b0 || ap_ready !== 1'b0 || ap_idle !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_pulse_width: got done=%b ready=%b idle=%b, want 0 0 1", name, ap_done, ap_ready, ap_idle);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_normalize();
    test_job("lsb_only",    1'b0, 13'd100,  64'h1,                   1'b0, 13'd38,   64'h4000_0000_0000_0000);
    test_job("shift0",      1'b0, 13'd1000, 64'h4000_0000_0000_0000, 1'b0, 13'd1000, 64'h4000_0000_0000_0000);
    test_job("bit63_jam",   1'b1, 13'd5,    64'h8000_0000_0000_0001, 1'b1, 13'd6,    64'h4000_0000_0000_0001);
    test_job("zero_sig",    1'b0, 13'd10,   64'h0,                   1'b0, 13'h1FCB, 64'h0);
    test_job("shift31",     1'b0, 13'd0,    64'h0000_0001_0000_0000, 1'b0, 13'h1FE2, 64'h4000_0000_0000_0000);
    test_job("shift23",     1'b1, 13'd50,   64'h0000_00FF_FFFF_FFFF, 1'b1, 13'd27,   64'h7FFF_FFFF_FF80_0000);
    test_job("exp_wrap",    1'b0, 13'h1000, 64'h1,                   1'b0, 13'h0FC2, 64'h4000_0000_0000_0000);
  endtask

  // Outputs must not follow the inputs while the block sits in IDLE.
  task automatic test_hold_idle();
    logic [63:0] sig_prev;
    logic [12:0] exp_prev;
    sig_prev = zSig_o; exp_prev = zExp_o;
    zSig = 64'hDEAD_BEEF_0000_1234; zExp = 13'd77; zSign = 1'b1;
    repeat (5) @(negedge ap_clk);
    n_checks++;
    if (zSig_o !== 64'h4000_0000_0000_0000 || zExp_o !== 13'h0FC2 || ap_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_hold: got sig=%h exp=%h done=%b, want sig=%h exp=%h done=0",
               zSig_o, zExp_o, ap_done, sig_prev, exp_prev);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int first_c;
    int second_c;
    bit idle_seen;
    pulses = 0; first_c = -1; second_c = -1; idle_seen = 0;
    zSign = 1'b0; zExp = 13'd100; zSig = 64'h1;
    ap_start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(posedge ap_clk);
      #1;
      if (c == 9) begin
        zExp = 13'd1000; zSig = 64'h4000_0000_0000_0000;
      end
      if (ap_idle !== 1'b0) idle_seen = 1;
      if (ap_done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          first_c = c;
          n_checks++;
          if (zSig_o !== 64'h4000_0000_0000_0000 || zExp_o !== 13'd38) begin
            n_fail++;
            $display("[TB] FAIL b2b_job1: got sig=%h exp=%h, want 4000000000000000 0026", zSig_o, zExp_o);
          end
        end else if (pulses == 2) begin
          second_c = c;
          n_checks++;
          if (zSig_o !== 64'h4000_0000_0000_0000 || zExp_o !== 13'd1000) begin
            n_fail++;
            $display("[TB] FAIL b2b_job2: got sig=%h exp=%h, want 4000000000000000 03e8", zSig_o, zExp_o);
          end
        end
      end
    end
    ap_start = 1'b0;
    n_checks++;
    if (pulses != 2 || first_c != 8 || second_c != 17) begin
      n_fail++;
      $display("[TB] FAIL b2b_timing: got %0d pulses at %0d,%0d, want 2 at 8,17", pulses, first_c, second_c);
    end
    n_checks++;
    if (idle_seen) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle: got idle=1 during run, want 0");
    end
    repeat (3) @(negedge ap_clk);
  endtask

  // Abort a job with reset in its third cycle. No result may appear afterwards.
  task automatic test_async_reset();
    bit done_seen;
    done_seen = 0;
    zSign = 1'b1; zExp = 13'd5; zSig = 64'h8000_0000_0000_0001;
    ap_start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge ap_clk);
      #1;
      ap_start = 1'b0;
    end
    #2;
    ap_rst_n = 1'b0;
    #1;
    n_checks++;
    if (zSig_o !== 64'd0 || zExp_o !== 13'd0 || zSign_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_outputs: got sig=%h exp=%h sign=%b, want all 0", zSig_o, zExp_o, zSign_o);
    end
    n_checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_ctrl: got idle=%b done=%b, want 1 0", ap_idle, ap_done);
    end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge ap_clk);
      #1;
      if (ap_done !== 1'b0) done_seen = 1;
    end
    n_checks++;
    if (done_seen || zSig_o !== 64'd0 || ap_idle !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL abort_no_result: got done_seen=%b sig=%h idle=%b, want 0 0 1", done_seen, zSig_o, ap_idle);
    end
  endtask

  initial begin
    test_reset();
    test_normalize();
    test_hold_idle();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
